// File: rtl/byte_mux2.sv
// Two-initiator to one-memory-port arbiter using an enable/hold handshake.
// Round-robin in FREE, grant pinned to the owner while the memory stalls (LOCKED).
module byte_mux2 #(
  parameter int unsigned DATA_BYTE = 4,
  parameter int unsigned ADDR_SIZE = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aEnable_i,
  input  logic                   aIsWrite_i,
  input  logic [DATA_BYTE-1:0]   aWriteMask_i,
  input  logic [ADDR_SIZE-1:0]   aAddr_i,
  input  logic [DATA_BYTE*8-1:0] aWriteData_i,
  output logic [DATA_BYTE*8-1:0] aReadData_o,
  output logic                   aHold_o,
  input  logic                   bEnable_i,
  input  logic                   bIsWrite_i,
  input  logic [DATA_BYTE-1:0]   bWriteMask_i,
  input  logic [ADDR_SIZE-1:0]   bAddr_i,
  input  logic [DATA_BYTE*8-1:0] bWriteData_i,
  output logic [DATA_BYTE*8-1:0] bReadData_o,
  output logic                   bHold_i,
  output logic                   memEnable_o,
  output logic                   memIsWrite_o,
  output logic [DATA_BYTE-1:0]   memWriteMask_o,
  output logic [ADDR_SIZE-1:0]   memAddr_o,
  output logic [DATA_BYTE*8-1:0] memWriteData_o,
  input  logic [DATA_BYTE*8-1:0] memReadData_i,
  input  logic                   memHold_i
);

  typedef enum logic {StFree, StLocked} state_e;

  // Initiator encoding throughout: 0 = A, 1 = B.
  state_e state_q;
  logic   owner_q;
  logic   prio_q;
  logic   rd_valid_q;
  logic   rd_owner_q;

  logic grant_valid;
  logic grant_sel;
  logic accept;
  logic sel_is_write;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = prio_q;
    unique case (state_q)
      StLocked: begin
        grant_sel   = owner_q;
        grant_valid = owner_q ? bEnable_i : aEnable_i;
      end
      StFree: begin
        if (aEnable_i && bEnable_i) begin
          grant_sel   = prio_q;
          grant_valid = 1'b1;
        end else if (aEnable_i) begin
          grant_sel   = 1'b0;
          grant_valid = 1'b1;
        end else if (bEnable_i) begin
          grant_sel   = 1'b1;
          grant_valid = 1'b1;
        end
      end
    endcase
  end

  assign sel_is_write = grant_sel ? bIsWrite_i : aIsWrite_i;
  assign accept       = grant_valid & ~memHold_i;

  always_comb begin
    memEnable_o    = 1'b0;
    memIsWrite_o   = 1'b0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    if (grant_valid) begin
      memEnable_o    = 1'b1;
      memIsWrite_o   = sel_is_write;
      memWriteMask_o = grant_sel ? bWriteMask_i : aWriteMask_i;
      memAddr_o      = grant_sel ? bAddr_i      : aAddr_i;
      memWriteData_o = grant_sel ? bWriteData_i : aWriteData_i;
    end
  end

  assign aHold_o = aEnable_i & ~(accept & ~grant_sel);
  assign bHold_i = bEnable_i & ~(accept &  grant_sel);

  assign aReadData_o = (rd_valid_q && !rd_owner_q) ? memReadData_i : '0;
  assign bReadData_o = (rd_valid_q &&  rd_owner_q) ? memReadData_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StFree;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_valid_q <= accept & ~sel_is_write;
      rd_owner_q <= grant_sel;
      if (accept) begin
        state_q <= StFree;
        prio_q  <= ~grant_sel;
      end else if (grant_valid) begin
        state_q <= StLocked;
        owner_q <= grant_sel;
      end else begin
        // Covers an owner abort: release the lock, leave prio as it was.
        state_q <= StFree;
      end
    end
  end

endmodule

// File: tb/tb_byte_mux2.sv
// Randomised + directed bench for byte_mux2 against a cycle-level reference model.
module tb_byte_mux2;
  localparam int DB = 4;
  localparam int AW = 32;
  localparam int DW = DB * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en[2], wr[2];
  logic [DB-1:0] mask[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];
  logic [DW-1:0] mrdata;
  logic          mhold;

  logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
  logic          a_hold, b_hold, mem_en, mem_wr;
  logic [DB-1:0] mem_mask;
  logic [AW-1:0] mem_addr;

  byte_mux2 #(.DATA_BYTE(DB), .ADDR_SIZE(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .aEnable_i(en[0]), .aIsWrite_i(wr[0]), .aWriteMask_i(mask[0]), .aAddr_i(addr[0]),
    .aWriteData_i(wdata[0]), .aReadData_o(a_rdata), .aHold_o(a_hold),
    .bEnable_i(en[1]), .bIsWrite_i(wr[1]), .bWriteMask_i(mask[1]), .bAddr_i(addr[1]),
    .bWriteData_i(wdata[1]), .bReadData_o(b_rdata), .bHold_i(b_hold),
    .memEnable_o(mem_en), .memIsWrite_o(mem_wr), .memWriteMask_o(mem_mask),
    .memAddr_o(mem_addr), .memWriteData_o(mem_wdata),
    .memReadData_i(mrdata), .memHold_i(mhold)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the port, whose turn it is, and the read in flight.
  bit m_locked = 0;
  int m_owner = 0;
  int m_prio = 0;
  bit m_rd_pending = 0;
  int m_rd_who = 0;
  bit last_hold[2] = '{0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int g;
    bit acc;
    logic [DW-1:0] exp_rd[2];
    if (rst) begin
      m_locked = 0; m_owner = 0; m_prio = 0; m_rd_pending = 0; m_rd_who = 0;
    end
    if (m_locked) g = en[m_owner] ? m_owner : -1;
    else if (en[0] && en[1]) g = m_prio;
    else if (en[0]) g = 0;
    else if (en[1]) g = 1;
    else g = -1;
    acc = (g >= 0) && !mhold;
    for (int x = 0; x < 2; x++) begin
      exp_rd[x] = (m_rd_pending && m_rd_who == x) ? mrdata : '0;
      last_hold[x] = en[x] && !(acc && g == x);
    end
    chk("mem_en", 64'(mem_en), 64'(g >= 0));
    chk("mem_wr", 64'(mem_wr), (g >= 0) ? 64'(wr[g]) : 64'd0);
    chk("mem_mask", 64'(mem_mask), (g >= 0) ? 64'(mask[g]) : 64'd0);
    chk("mem_addr", 64'(mem_addr), (g >= 0) ? 64'(addr[g]) : 64'd0);
    chk("mem_wdata", 64'(mem_wdata), (g >= 0) ? 64'(wdata[g]) : 64'd0);
    chk("a_hold", 64'(a_hold), 64'(last_hold[0]));
    chk("b_hold", 64'(b_hold), 64'(last_hold[1]));
    chk("a_rdata", 64'(a_rdata), 64'(exp_rd[0]));
    chk("b_rdata", 64'(b_rdata), 64'(exp_rd[1]));
    if (!rst) begin
      if (acc) begin
        m_locked = 0;
        m_prio = 1 - g;
      end else begin
        m_locked = (g >= 0);
        if (g >= 0) m_owner = g;
      end
      m_rd_pending = acc && !wr[g];
      if (acc) m_rd_who = g;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int x = 0; x < 2; x++) begin
      en[x] = 0; wr[x] = 0; mask[x] = '0; addr[x] = '0; wdata[x] = '0;
    end
  endtask

  task automatic req(input int x, input bit w, input logic [DB-1:0] m,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    en[x] = 1; wr[x] = w; mask[x] = m; addr[x] = a; wdata[x] = d;
  endtask

  logic [AW-1:0] rr_addr[4];

  initial begin
    idle();
    mhold = 0;
    mrdata = '0;
    rst = 1;
    // Reset state
    settle();
    chk("rst_a_hold", 64'(a_hold), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_a_rdata", 64'(a_rdata), 64'd0);
    adv();
    rst = 0;

    // Single read from A
    req(0, 0, 4'hF, 32'h10, '0);
    settle();
    chk("rd_mem_addr", 64'(mem_addr), 64'h10);
    chk("rd_mem_en", 64'(mem_en), 64'd1);
    chk("rd_a_hold", 64'(a_hold), 64'd0);
    adv();
    idle();
    mrdata = 32'hDEADBEEF;
    settle();
    chk("rd_a_data", 64'(a_rdata), 64'hDEADBEEF);
    chk("rd_b_data", 64'(b_rdata), 64'd0);
    adv();

    // Contention after reset: A, B, A, B
    rst = 1;
    settle();
    adv();
    rst = 0;
    mrdata = '0;
    req(0, 1, 4'h1, 32'h100, 32'hA);
    req(1, 1, 4'h2, 32'h200, 32'hB);
    rr_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_addr", 64'(mem_addr), 64'(rr_addr[i]));
      chk("rr_a_hold", 64'(a_hold), 64'(i % 2));
      chk("rr_b_hold", 64'(b_hold), 64'(1 - i % 2));
      adv();
    end

    // Lock under stall: B held 3 cycles, A waits
    idle();
    req(1, 0, 4'hF, 32'h200, '0);
    mhold = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) req(0, 0, 4'hF, 32'h100, '0);
      if (i == 3) mhold = 0;
      settle();
      chk("lock_addr", 64'(mem_addr), 64'h200);
      if (i > 0) chk("lock_a_hold", 64'(a_hold), 64'd1);
      adv();
    end
    en[1] = 0;
    settle();
    chk("lock_next_addr", 64'(mem_addr), 64'h100);
    chk("lock_next_a_hold", 64'(a_hold), 64'd0);
    adv();

    // Owner abort: A locked, then drops enable; prio stays B
    idle();
    req(0, 0, 4'hF, 32'h100, '0);
    mhold = 1;
    settle();
    adv();
    idle();
    mhold = 0;
    settle();
    chk("abort_mem_en", 64'(mem_en), 64'd0);
    adv();
    req(0, 0, 4'hF, 32'h100, '0);
    req(1, 0, 4'hF, 32'h200, '0);
    settle();
    chk("abort_prio_b", 64'(mem_addr), 64'h200);
    adv();

    // Write then read
    idle();
    req(0, 1, 4'b0011, 32'h40, 32'h12345678);
    mrdata = 32'h0BAD0BAD;
    settle();
    chk("wr_is_write", 64'(mem_wr), 64'd1);
    chk("wr_mask", 64'(mem_mask), 64'h3);
    chk("wr_data", 64'(mem_wdata), 64'h12345678);
    adv();
    idle();
    req(1, 0, 4'hF, 32'h44, '0);
    mrdata = 32'hCAFEF00D;
    settle();
    chk("wr_rd_is_write", 64'(mem_wr), 64'd0);
    chk("wr_rd_addr", 64'(mem_addr), 64'h44);
    chk("wr_no_a_data", 64'(a_rdata), 64'd0);
    chk("wr_no_b_data", 64'(b_rdata), 64'd0);
    adv();
    idle();
    mrdata = 32'h55AA55AA;
    settle();
    chk("wr_b_data", 64'(b_rdata), 64'h55AA55AA);
    chk("wr_a_data0", 64'(a_rdata), 64'd0);
    adv();

    // Reset mid-read drops the in-flight read
    req(0, 0, 4'hF, 32'h100, '0);
    settle();
    adv();
    idle();
    rst = 1;
    mrdata = 32'h11112222;
    settle();
    chk("rstrd_a_data", 64'(a_rdata), 64'd0);
    adv();
    rst = 0;
    req(0, 0, 4'hF, 32'h100, '0);
    req(1, 0, 4'hF, 32'h200, '0);
    settle();
    chk("rstrd_prio_a", 64'(mem_addr), 64'h100);
    adv();

    // Random traffic, honouring "fields stable while held" except rare aborts
    idle();
    for (int c = 0; c < 4000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!(last_hold[x] && $urandom_range(0, 19) != 0)) begin
          en[x] = $urandom_range(0, 1) == 1;
          wr[x] = $urandom_range(0, 1) == 1;
          mask[x] = DB'($urandom);
          addr[x] = $urandom;
          wdata[x] = $urandom;
        end
      end
      mhold = $urandom_range(0, 3) == 0;
      mrdata = $urandom;
      rst = $urandom_range(0, 199) == 0;
      settle();
      adv();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
